// File: rtl/as_fetchstage_if.sv
// Fetch-stage bus: instruction-memory request/grant/response, execute redirect and
// the decode-side valid/ready handshake. The fetch stage is the master.
interface as_fetchstage_if #(
  parameter int REG_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req_o;
  logic [REG_WIDTH-1:0]   imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [INSTR_WIDTH-1:0] imem_rdata_i;
  logic                   redirect_i;
  logic [REG_WIDTH-1:0]   redirect_pc_i;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [REG_WIDTH-1:0]   pc_o;
  logic [REG_WIDTH-1:0]   pc_plus4_o;
  logic                   valid_o;
  logic                   ready_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_o, pc_o, pc_plus4_o, valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, pc_o, pc_plus4_o, valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/as_fetchstage.sv
// RV64I instruction fetch stage: owns the PC, keeps one memory request in flight and
// buffers returned words with their PC in a small FIFO for decode.
module as_fetchstage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  as_fetchstage_if.master bus
);
  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {RUN = 2'b00, WAIT = 2'b01, DROP = 2'b10} state_t;

  state_t           state_r;
  logic [63:0]      fetch_pc_r;
  logic [63:0]      req_pc_r;
  logic [31:0]      instr_mem_r [DEPTH];
  logic [63:0]      pc_mem_r    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             valid_s;
  logic             req_s;
  logic             grant_s;
  logic             push_s;
  logic             pop_s;
  logic [63:0]      redirect_target_s;
  logic [63:0]      head_pc_s;

  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

  // Handshake qualification; a redirect cancels this cycle's request, push and pop
  always_comb begin
    valid_s           = rst_i && (count_r != {CNT_W{1'b0}});
    req_s             = rst_i && (state_r == RUN) && (count_r < DEPTH_C) && !bus.redirect_i;
    grant_s           = req_s && bus.imem_gnt_i;
    push_s            = (state_r == WAIT) && bus.imem_rvalid_i && !bus.redirect_i;
    pop_s             = valid_s && bus.ready_i && !bus.redirect_i;
    redirect_target_s = word_align(bus.redirect_pc_i);
    head_pc_s         = pc_mem_r[rd_ptr_r];
  end

  assign bus.imem_req_o  = req_s;
  assign bus.imem_addr_o = rst_i ? fetch_pc_r : RESET_PC;
  assign bus.valid_o     = valid_s;
  assign bus.instr_o     = valid_s ? instr_mem_r[rd_ptr_r] : NOP;
  assign bus.pc_o        = valid_s ? head_pc_s : 64'h0;
  assign bus.pc_plus4_o  = valid_s ? (head_pc_s + 64'd4) : 64'h0;

  // Program counter, fetch FSM and instruction FIFO
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r    <= RUN;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= RESET_PC;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= bus.imem_rdata_i;
        pc_mem_r[wr_ptr_r]    <= req_pc_r;
      end
      if (bus.redirect_i) begin
        fetch_pc_r <= redirect_target_s;
        wr_ptr_r   <= {PTR_W{1'b0}};
        rd_ptr_r   <= {PTR_W{1'b0}};
        count_r    <= {CNT_W{1'b0}};
        // An outstanding response must still be absorbed unless it lands right now
        case (state_r)
          RUN:        state_r <= RUN;
          WAIT, DROP: state_r <= bus.imem_rvalid_i ? RUN : DROP;
          default:    state_r <= RUN;
        endcase
      end else begin
        case (state_r)
          RUN: begin
            if (grant_s) begin
              req_pc_r   <= fetch_pc_r;
              fetch_pc_r <= fetch_pc_r + 64'd4;
              state_r    <= WAIT;
            end
          end
          WAIT, DROP: begin
            if (bus.imem_rvalid_i) begin
              state_r <= RUN;
            end
          end
          default: state_r <= RUN;
        endcase
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        if (push_s && !pop_s) begin
          count_r <= count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
          count_r <= count_r - CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_as_fetchstage.sv
// Self-checking bench: the model tracks the architectural instruction stream (next PC
// decode should see, next address memory should be asked for) plus a one-slot memory.
module tb_as_fetchstage;
  localparam logic [63:0] PC0  = 64'h1000;
  localparam logic [63:0] PCW  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  as_fetchstage_if bus_m ();
  as_fetchstage_if bus_w ();

  as_fetchstage #(.RESET_PC(PC0), .DEPTH(2)) dut   (.clk_i(clk), .rst_i(rst), .bus(bus_m));
  as_fetchstage #(.RESET_PC(PCW), .DEPTH(2)) dut_w (.clk_i(clk), .rst_i(rst), .bus(bus_w));

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_pc, exp_req;
  bit          pend;
  int          pend_cnt;
  logic [63:0] pend_addr, pend_addr_w;
  bit          after_red;
  logic [63:0] grant_q[$], pop_q[$], wgrant_q[$], wpop_q[$], wpop4_q[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_idle();
    bus_m.imem_gnt_i = 1'b0;    bus_w.imem_gnt_i = 1'b0;
    bus_m.imem_rvalid_i = 1'b0; bus_w.imem_rvalid_i = 1'b0;
    bus_m.imem_rdata_i = 32'h0; bus_w.imem_rdata_i = 32'h0;
    bus_m.redirect_i = 1'b0;    bus_w.redirect_i = 1'b0;
    bus_m.redirect_pc_i = 64'h0; bus_w.redirect_pc_i = 64'h0;
    bus_m.ready_i = 1'b0;       bus_w.ready_i = 1'b0;
  endtask

  task automatic clear_model(input bit clear_mem);
    exp_pc = PC0; exp_req = PC0; after_red = 1'b0;
    if (clear_mem) pend = 1'b0;
    grant_q.delete(); pop_q.delete(); wgrant_q.delete(); wpop_q.delete(); wpop4_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model(1'b1);
  endtask

  // One clock: drive inputs, play memory, check the stream, advance past the edge.
  task automatic run_cycle(input bit red, input logic [63:0] rpc, input bit rdy,
                           input int lat, input bit allow);
    bit rv, g;
    bus_m.redirect_i = red; bus_w.redirect_i = red;
    bus_m.redirect_pc_i = rpc; bus_w.redirect_pc_i = rpc;
    bus_m.ready_i = rdy; bus_w.ready_i = rdy;
    rv = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin rv = 1'b1; pend = 1'b0; end
    end
    bus_m.imem_rvalid_i = rv; bus_w.imem_rvalid_i = rv;
    bus_m.imem_rdata_i = rv ? mem_word(pend_addr) : $urandom;
    bus_w.imem_rdata_i = rv ? mem_word(pend_addr_w) : $urandom;
    #1;
    if (after_red) begin
      n_tests++;
      if (bus_m.valid_o !== 1'b0) begin n_fail++; $display("FAIL valid_after_redirect: got %b expected 0", bus_m.valid_o); end
    end
    if (!bus_m.valid_o) begin
      n_tests++;
      if (bus_m.instr_o !== NOPI || bus_m.pc_o !== 64'h0 || bus_m.pc_plus4_o !== 64'h0) begin
        n_fail++; $display("FAIL idle_outputs: got %h/%h/%h expected %h/0/0", bus_m.instr_o, bus_m.pc_o, bus_m.pc_plus4_o, NOPI);
      end
    end
    if (red) begin
      n_tests++;
      if (bus_m.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL req_during_redirect: got %b expected 0", bus_m.imem_req_o); end
    end
    if (allow && bus_m.imem_req_o && pend) begin
      n_tests++; n_fail++; $display("FAIL second_outstanding: got req=1 expected 0");
    end
    g = allow && (bus_m.imem_req_o === 1'b1) && !pend;
    bus_m.imem_gnt_i = g; bus_w.imem_gnt_i = g;
    if (g) begin
      n_tests++;
      if (bus_m.imem_addr_o !== exp_req) begin n_fail++; $display("FAIL req_addr: got %h expected %h", bus_m.imem_addr_o, exp_req); end
      grant_q.push_back(bus_m.imem_addr_o);
      wgrant_q.push_back(bus_w.imem_addr_o);
      exp_req = exp_req + 64'd4;
      pend = 1'b1; pend_cnt = lat;
      pend_addr = bus_m.imem_addr_o; pend_addr_w = bus_w.imem_addr_o;
    end
    if (bus_m.valid_o && rdy && !red) begin
      n_tests++;
      if (bus_m.pc_o !== exp_pc || bus_m.instr_o !== mem_word(exp_pc) || bus_m.pc_plus4_o !== exp_pc + 64'd4) begin
        n_fail++; $display("FAIL pop_stream: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                           bus_m.pc_o, bus_m.instr_o, bus_m.pc_plus4_o, exp_pc, mem_word(exp_pc), exp_pc + 64'd4);
      end
      pop_q.push_back(bus_m.pc_o);
      exp_pc = exp_pc + 64'd4;
    end
    if (bus_w.valid_o && rdy && !red) begin
      n_tests++;
      if (bus_w.instr_o !== mem_word(bus_w.pc_o)) begin n_fail++; $display("FAIL wrap_instr: got %h expected %h", bus_w.instr_o, mem_word(bus_w.pc_o)); end
      wpop_q.push_back(bus_w.pc_o);
      wpop4_q.push_back(bus_w.pc_plus4_o);
    end
    if (red) begin exp_pc = rpc & ~64'h3; exp_req = rpc & ~64'h3; end
    after_red = red;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    bus_m.imem_rvalid_i = 1'b1; bus_m.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus_m.imem_req_o !== 1'b0 || bus_m.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b/%b expected 0/0", bus_m.imem_req_o, bus_m.valid_o); end
    n_tests++;
    if (bus_m.instr_o !== NOPI || bus_m.pc_o !== 64'h0 || bus_m.pc_plus4_o !== 64'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h/%h expected %h/0/0", bus_m.instr_o, bus_m.pc_o, bus_m.pc_plus4_o, NOPI);
    end
    n_tests++;
    if (bus_m.imem_addr_o !== PC0 || bus_w.imem_addr_o !== PCW) begin
      n_fail++; $display("FAIL reset_addr: got %h/%h expected %h/%h", bus_m.imem_addr_o, bus_w.imem_addr_o, PC0, PCW);
    end
    drive_idle();
    rst = 1'b1;
    clear_model(1'b1);
  endtask

  task automatic test_stream();
    apply_reset();
    repeat (8) run_cycle(1'b0, 64'h0, 1'b1, 1, 1'b1);
    n_tests++;
    if (grant_q.size() < 3 || pop_q.size() < 3) begin
      n_fail++; $display("FAIL stream_count: got grants=%0d pops=%0d expected >=3", grant_q.size(), pop_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (grant_q[i] !== PC0 + 64'(4 * i) || pop_q[i] !== PC0 + 64'(4 * i)) begin
          n_fail++; $display("FAIL stream_seq%0d: got %h/%h expected %h", i, grant_q[i], pop_q[i], PC0 + 64'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (12) run_cycle(1'b0, 64'h0, 1'b0, 1, 1'b1);
    n_tests++;
    if (grant_q.size() != 2 || bus_m.imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got grants=%0d req=%b expected 2/0", grant_q.size(), bus_m.imem_req_o);
    end
    n_tests++;
    if (bus_m.valid_o !== 1'b1 || bus_m.pc_o !== PC0) begin
      n_fail++; $display("FAIL bp_head_hold: got valid=%b pc=%h expected 1/%h", bus_m.valid_o, bus_m.pc_o, PC0);
    end
    repeat (10) run_cycle(1'b0, 64'h0, 1'b1, 1, 1'b1);
    n_tests++;
    if (pop_q.size() < 3 || grant_q.size() < 3) begin
      n_fail++; $display("FAIL bp_drain_count: got pops=%0d grants=%0d expected >=3", pop_q.size(), grant_q.size());
    end else begin
      n_tests++;
      if (pop_q[0] !== PC0 || pop_q[1] !== PC0 + 64'd4 || grant_q[2] !== PC0 + 64'd8) begin
        n_fail++; $display("FAIL bp_drain_order: got %h %h next_req=%h expected %h %h %h",
                           pop_q[0], pop_q[1], grant_q[2], PC0, PC0 + 64'd4, PC0 + 64'd8);
      end
    end
  endtask

  task automatic test_redirect_drop();
    apply_reset();
    run_cycle(1'b0, 64'h0, 1'b1, 4, 1'b1);
    run_cycle(1'b1, 64'h2003, 1'b1, 1, 1'b1);
    repeat (10) run_cycle(1'b0, 64'h0, 1'b1, 1, 1'b1);
    n_tests++;
    if (grant_q.size() < 2 || pop_q.size() < 1) begin
      n_fail++; $display("FAIL drop_count: got grants=%0d pops=%0d expected >=2/>=1", grant_q.size(), pop_q.size());
    end else begin
      n_tests++;
      if (grant_q[1] !== 64'h2000 || pop_q[0] !== 64'h2000) begin
        n_fail++; $display("FAIL drop_target: got req=%h pc=%h expected 2000/2000", grant_q[1], pop_q[0]);
      end
    end
  endtask

  task automatic test_redirect_rvalid();
    bit found;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_m.valid_o && pend && pend_cnt == 1) begin found = 1'b1; break; end
      run_cycle(1'b0, 64'h0, 1'b0, 2, 1'b1);
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL coincide_setup: got timeout expected 1 entry with response due"); end
    run_cycle(1'b1, 64'h3000, 1'b0, 1, 1'b1);
    drive_idle();
    #1;
    n_tests++;
    if (bus_m.valid_o !== 1'b0 || bus_m.imem_req_o !== 1'b1 || bus_m.imem_addr_o !== 64'h3000) begin
      n_fail++; $display("FAIL coincide_next: got valid=%b req=%b addr=%h expected 0/1/3000",
                         bus_m.valid_o, bus_m.imem_req_o, bus_m.imem_addr_o);
    end
    repeat (6) run_cycle(1'b0, 64'h0, 1'b1, 1, 1'b1);
    n_tests++;
    if (pop_q.size() < 1 || pop_q[0] !== 64'h3000) begin
      n_fail++; $display("FAIL coincide_first_pc: got pops=%0d expected first pc 3000", pop_q.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    repeat (8) run_cycle(1'b0, 64'h0, 1'b1, 1, 1'b1);
    n_tests++;
    if (wgrant_q.size() < 2 || wpop_q.size() < 2) begin
      n_fail++; $display("FAIL wrap_count: got grants=%0d pops=%0d expected >=2", wgrant_q.size(), wpop_q.size());
    end else begin
      n_tests++;
      if (wgrant_q[0] !== PCW || wgrant_q[1] !== 64'h0) begin
        n_fail++; $display("FAIL wrap_addr: got %h %h expected %h 0", wgrant_q[0], wgrant_q[1], PCW);
      end
      n_tests++;
      if (wpop_q[0] !== PCW || wpop4_q[0] !== 64'h0 || wpop_q[1] !== 64'h0) begin
        n_fail++; $display("FAIL wrap_pc: got pc=%h pc4=%h next=%h expected %h 0 0", wpop_q[0], wpop4_q[0], wpop_q[1], PCW);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    for (int i = 0; i < 20 && grant_q.size() < 3; i++) run_cycle(1'b0, 64'h0, 1'b1, 3, 1'b1);
    n_tests++;
    if (!pend) begin n_fail++; $display("FAIL rstwait_setup: got no outstanding request expected 1"); end
    rst = 1'b0;
    drive_idle();
    bus_m.ready_i = 1'b1; bus_w.ready_i = 1'b1;
    if (pend) pend_cnt--;
    #1;
    n_tests++;
    if (bus_m.imem_req_o !== 1'b0 || bus_m.valid_o !== 1'b0 || bus_m.instr_o !== NOPI ||
        bus_m.pc_o !== 64'h0 || bus_m.pc_plus4_o !== 64'h0 || bus_m.imem_addr_o !== PC0) begin
      n_fail++; $display("FAIL rstwait_outputs: got req=%b valid=%b instr=%h pc=%h addr=%h expected 0/0/%h/0/%h",
                         bus_m.imem_req_o, bus_m.valid_o, bus_m.instr_o, bus_m.pc_o, bus_m.imem_addr_o, NOPI, PC0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model(1'b0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 64'h0, 1'b1, 1, 1'b0);
      n_tests++;
      if (bus_m.valid_o !== 1'b0) begin n_fail++; $display("FAIL rstwait_stale%0d: got valid=%b expected 0", i, bus_m.valid_o); end
    end
    repeat (8) run_cycle(1'b0, 64'h0, 1'b1, 1, 1'b1);
    n_tests++;
    if (grant_q.size() < 1 || pop_q.size() < 1 || grant_q[0] !== PC0 || pop_q[0] !== PC0) begin
      n_fail++; $display("FAIL rstwait_restart: got grants=%0d pops=%0d expected first req/pc %h", grant_q.size(), pop_q.size(), PC0);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom % 20) == 0, {$urandom, $urandom}, ($urandom % 3) != 0,
                1 + int'($urandom % 3), ($urandom % 4) != 0);
    end
    n_tests++;
    if (pop_q.size() < 20) begin n_fail++; $display("FAIL random_progress: got %0d pops expected >=20", pop_q.size()); end
  endtask

  initial begin
    drive_idle();
    clear_model(1'b1);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_rvalid();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/as_fetchstage.md
# as_fetchstage

Instruction fetch stage of the RV64I pipeline. It is the producer end of the instruction path that the decode stage consumes. It owns the program counter and issues word requests to the instruction memory over a request/grant/response handshake. Returned instructions are buffered with their PC in a small FIFO, and each entry is presented to decode with a valid/ready handshake. A redirect from execute (taken branch/jump) retargets the PC, flushes the buffer and discards any in-flight response.

## Interface
- `RESET_PC`, default 64'h0: PC fetched first after reset.
- `DEPTH`, default 2: instruction FIFO entries (power of two, ≥2).

- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `imem_req_o`  out  1  fetch request; held with `imem_addr_o` stable until granted.
- `imem_addr_o`  out  `reg_width`  byte address of requested word; bits[1:0] always 0.
- `imem_gnt_i`  in  1  memory accepts request this cycle (`imem_req_o` & `imem_gnt_i`).
- `imem_rvalid_i`  in  1  response valid; ≥1 cycle after grant, exactly one per grant.
- `imem_rdata_i`  in  `instr_width`  returned instruction.
- `redirect_i`  in  1  retarget fetch (branch taken / jump).
- `redirect_pc_i`  in  `reg_width`  new PC; bits[1:0] ignored (forced 0).
- `instr_o`  out  `instr_width`  head-of-FIFO instruction; 32'h00000013 (NOP) when `valid_o`=0.
- `pc_o`  out  `reg_width`  PC of `instr_o`; 0 when `valid_o`=0.
- `pc_plus4_o`  out  `reg_width`  `pc_o`+4 (mod 2^64); 0 when `valid_o`=0.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  decode accepts head; pop when `valid_o` & `ready_i`.

## Operation
- Registers: `fetch_pc` (next address to request), `req_pc` (address of outstanding request), FIFO of {instr, pc}, count, 2-bit FSM.
- FSM states:
  - RUN: no request outstanding.
  - WAIT: one granted request outstanding, response wanted.
  - DROP: one granted request outstanding, response to be discarded.
- Request rule: `imem_req_o` = (state==RUN) & (count < DEPTH) & !`redirect_i`; `imem_addr_o` = `fetch_pc`. At most one outstanding request, so the FIFO can never overflow.
- RUN, grant without redirect → WAIT; `req_pc` ← `fetch_pc`; `fetch_pc` ← `fetch_pc`+4.
- WAIT, `imem_rvalid_i` without redirect → push {`imem_rdata_i`, `req_pc`}; → RUN.
- DROP, `imem_rvalid_i` → data discarded; → RUN.
- Redirect (any state):
  - `fetch_pc` ← {`redirect_pc_i`[63:2], 2'b00}; FIFO flushed (count←0); any pop in the same cycle is ignored.
  - From WAIT → DROP, unless `imem_rvalid_i` is high the same cycle, in which case the response is discarded → RUN.
  - From DROP: stays DROP unless `imem_rvalid_i` is high the same cycle, in which case → RUN.
  - From RUN → RUN; the request is suppressed that cycle.
- Simultaneous push and pop: both occur; count unchanged.
- PC arithmetic is modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal.
- `imem_rvalid_i` while in RUN is a protocol error: ignored, no push.

## Timing
- Reset (`rst_i`=0 at an edge):
  - `fetch_pc` ← `RESET_PC`; state ← RUN; FIFO empty.
  - Outputs while `rst_i`=0: `imem_req_o`=0, `valid_o`=0, `instr_o`=NOP, `pc_o`=0, `pc_plus4_o`=0, `imem_addr_o`=`RESET_PC`.
  - Reset in WAIT/DROP abandons the outstanding response; a later `imem_rvalid_i` is ignored per the RUN rule.
- First request: cycle after `rst_i` rises.
- Latency: `imem_rvalid_i` at edge N → `valid_o`=1 after edge N (the following cycle).
- Next request: asserted the cycle after the response (RUN). Peak throughput with 1-cycle memory is one instruction per 2 cycles.
- Redirect at edge N:
  - `valid_o`=0 after N.
  - Request to the new PC asserted in cycle N+1 if in RUN; otherwise the cycle after the dropped response arrives.
- `valid_o`/`instr_o`/`pc_o` hold stable while `valid_o` & !`ready_i`.

## Test plan
- Reset, `RESET_PC`=64'h1000, memory grants immediately with 1-cycle response, `ready_i`=1 → addresses 0x1000, 0x1004, 0x1008 requested; `pc_o` sequence 0x1000, 0x1004, 0x1008, `pc_plus4_o` +4 each, `instr_o` matches memory.
- `ready_i`=0 throughout → exactly `DEPTH` (2) entries buffered, then `imem_req_o`=0; raise `ready_i` → entries drain in order, fetching resumes at 0x1008.
- Grant at cycle 5, response delayed to cycle 9, `redirect_i`=1 with `redirect_pc_i`=0x2003 at cycle 6 → cycle-9 data not pushed; next request address 0x2000; first `pc_o` after redirect is 0x2000.
- Redirect coincident with `imem_rvalid_i` in WAIT, FIFO holding 1 entry → FIFO empty next cycle, `valid_o`=0, request to the redirect target the cycle after.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC → second request address 0x0, `pc_plus4_o` of first instruction = 0.
- `rst_i` low for one cycle while in WAIT, stale `imem_rvalid_i` two cycles later → no push, outputs at reset values, fetch restarts at `RESET_PC`.
